// File: rtl/pipe_stage_hs_pkg.sv
// Shared types and constants for the handshaked pipeline stage register.
package pipe_stage_hs_pkg;

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} pipe_state_t;

  localparam int unsigned CntWMax = 64;

  // All-ones value of a cnt_w-bit counter; the saturation point of the stall counter.
  function automatic logic [CntWMax-1:0] cnt_sat_value(input int unsigned cnt_w);
    logic [CntWMax-1:0] ones;
    ones = '1;
    return ones >> (CntWMax - cnt_w);
  endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready channel carrying a payload and its control bits between pipeline stages.
interface pipe_stage_hs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 2
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_hs_slot.sv
// One pipeline entry (valid + data + ctrl); clear drops the entry and zeroes ctrl.
module pipe_stage_hs_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Data survives a clear; only valid and ctrl must read as a bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_hs.sv
// Parametrised pipeline stage register with valid/ready handshake, flush, optional skid
// entry and a saturating stall counter.
import pipe_stage_hs_pkg::*;

module pipe_stage_hs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  pipe_stage_hs_if.slave   io_up,
  pipe_stage_hs_if.master  io_dn,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_sat_value(CNT_W));

  pipe_state_t       r_state, w_state_d;
  logic              w_in_ready, w_in_fire, w_out_fire;
  logic              w_m_load, w_m_clear, w_m_from_s, w_s_load, w_s_clear;
  logic              w_m_valid, w_s_valid;
  logic [DATA_W-1:0] w_m_data, w_s_data, w_m_ld_data;
  logic [CTRL_W-1:0] w_m_ctrl, w_s_ctrl, w_m_ld_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  generate
    if (SKID != 0) begin : g_rdy_reg
      // Depends only on the state register, so no combinational path from out_ready.
      assign w_in_ready = (r_state != StFull);
    end else begin : g_rdy_comb
      assign w_in_ready = ~w_m_valid | io_dn.ready;
    end
  endgenerate

  assign w_in_fire  = io_up.valid & w_in_ready;
  assign w_out_fire = w_m_valid & io_dn.ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (i_flush) begin
      w_state_d = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: if (w_in_fire) w_state_d = StBusy;
        StBusy: begin
          if (w_in_fire && !w_out_fire && (SKID != 0)) begin
            w_state_d = StFull;
          end else if (!w_in_fire && w_out_fire) begin
            w_state_d = StEmpty;
          end
        end
        StFull:  if (w_out_fire) w_state_d = StBusy;
        default: w_state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    w_m_load   = 1'b0;
    w_m_clear  = 1'b0;
    w_m_from_s = 1'b0;
    w_s_load   = 1'b0;
    w_s_clear  = 1'b0;
    if (i_flush) begin
      w_m_clear = 1'b1;
      w_s_clear = 1'b1;
    end else begin
      unique case (r_state)
        StEmpty: w_m_load = w_in_fire;
        StBusy: begin
          if (w_in_fire && w_out_fire) begin
            w_m_load = 1'b1;
          end else if (w_in_fire) begin
            w_s_load = 1'b1;
          end else if (w_out_fire) begin
            w_m_clear = 1'b1;
          end
        end
        StFull: begin
          if (w_out_fire && w_s_valid) begin
            w_m_load   = 1'b1;
            w_m_from_s = 1'b1;
            w_s_clear  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_m_ld_data = w_m_from_s ? w_s_data : io_up.data;
  assign w_m_ld_ctrl = w_m_from_s ? w_s_ctrl : io_up.ctrl;

  pipe_stage_hs_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot_m (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_m_load),
    .i_clear (w_m_clear),
    .i_data  (w_m_ld_data),
    .i_ctrl  (w_m_ld_ctrl),
    .o_valid (w_m_valid),
    .o_data  (w_m_data),
    .o_ctrl  (w_m_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_stage_hs_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot_s (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_data  (io_up.data),
        .i_ctrl  (io_up.ctrl),
        .o_valid (w_s_valid),
        .o_data  (w_s_data),
        .o_ctrl  (w_s_ctrl)
      );
    end else begin : g_no_skid
      assign w_s_valid = 1'b0;
      assign w_s_data  = '0;
      assign w_s_ctrl  = '0;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_m_valid && !io_dn.ready && (r_stall_cnt != CntMax)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign io_up.ready = w_in_ready;
  assign io_dn.valid = w_m_valid;
  assign io_dn.data  = w_m_data;
  assign io_dn.ctrl  = w_m_ctrl;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three instances (skid, skid with 4-bit counter, no skid) share
// one stimulus; a per-instance queue holds the entries expected downstream.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        tb_reset, tb_flush, tb_in_valid, tb_out_ready;
  logic [31:0] tb_in_data;
  logic [1:0]  tb_in_ctrl;
  logic [15:0] cnt1, cnt0;
  logic [3:0]  cnt4;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [33:0] q1[$];
  logic [33:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(2)) up1 ();
  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(2)) dn1 ();
  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(2)) up4 ();
  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(2)) dn4 ();
  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(2)) up0 ();
  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(2)) dn0 ();

  assign up1.valid = tb_in_valid;
  assign up1.data  = tb_in_data;
  assign up1.ctrl  = tb_in_ctrl;
  assign dn1.ready = tb_out_ready;
  assign up4.valid = tb_in_valid;
  assign up4.data  = tb_in_data;
  assign up4.ctrl  = tb_in_ctrl;
  assign dn4.ready = tb_out_ready;
  assign up0.valid = tb_in_valid;
  assign up0.data  = tb_in_data;
  assign up0.ctrl  = tb_in_ctrl;
  assign dn0.ready = tb_out_ready;

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(2), .SKID(1), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_reset(tb_reset), .i_flush(tb_flush),
    .io_up(up1), .io_dn(dn1), .o_stall_cnt(cnt1)
  );
  pipe_stage_hs #(.DATA_W(32), .CTRL_W(2), .SKID(1), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(tb_reset), .i_flush(tb_flush),
    .io_up(up4), .io_dn(dn4), .o_stall_cnt(cnt4)
  );
  pipe_stage_hs #(.DATA_W(32), .CTRL_W(2), .SKID(0), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_reset(tb_reset), .i_flush(tb_flush),
    .io_up(up0), .io_dn(dn0), .o_stall_cnt(cnt0)
  );

  // Scoreboard: pop on every downstream transfer, push on every accepted upstream entry.
  always @(negedge clk) begin : mon
    logic [33:0] e;
    if (tb_reset) begin
      q1.delete();
      q0.delete();
    end else begin
      n_checks++;
      if (!dn1.valid && dn1.ctrl !== 2'b00) begin
        n_errors++; $display("FAIL bubble_ctrl_skid: got %b want 00", dn1.ctrl);
      end
      n_checks++;
      if (!dn0.valid && dn0.ctrl !== 2'b00) begin
        n_errors++; $display("FAIL bubble_ctrl_noskid: got %b want 00", dn0.ctrl);
      end
      if (dn1.valid && tb_out_ready) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_errors++; $display("FAIL sb_skid: got %h want no entry", {dn1.ctrl, dn1.data});
        end else begin
          e = q1.pop_front();
          if ({dn1.ctrl, dn1.data} !== e) begin
            n_errors++; $display("FAIL sb_skid: got %h want %h", {dn1.ctrl, dn1.data}, e);
          end
        end
      end
      if (dn0.valid && tb_out_ready) begin
        n_checks++;
        if (q0.size() == 0) begin
          n_errors++; $display("FAIL sb_noskid: got %h want no entry", {dn0.ctrl, dn0.data});
        end else begin
          e = q0.pop_front();
          if ({dn0.ctrl, dn0.data} !== e) begin
            n_errors++; $display("FAIL sb_noskid: got %h want %h", {dn0.ctrl, dn0.data}, e);
          end
        end
      end
      if (tb_flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (tb_in_valid && up1.ready) q1.push_back({tb_in_ctrl, tb_in_data});
        if (tb_in_valid && up0.ready) q0.push_back({tb_in_ctrl, tb_in_data});
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] c,
                       input logic ordy, input logic fl);
    tb_in_valid  = v;
    tb_in_data   = d;
    tb_in_ctrl   = c;
    tb_out_ready = ordy;
    tb_flush     = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tb_reset = 1'b1;
    drive(1'b1, 32'h55, 2'b11, 1'b0, 1'b0);
    repeat (2) cyc();
    n_checks++;
    if (dn1.valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", dn1.valid); end
    n_checks++;
    if (dn1.data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", dn1.data); end
    n_checks++;
    if (dn1.ctrl !== 2'b00) begin n_errors++; $display("FAIL reset_ctrl: got %b want 00", dn1.ctrl); end
    n_checks++;
    if (up1.ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", up1.ready); end
    n_checks++;
    if (cnt1 !== 16'd0) begin n_errors++; $display("FAIL reset_stall_cnt: got %0d want 0", cnt1); end
    n_checks++;
    if (up0.ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready_noskid: got %b want 1", up0.ready); end
    tb_reset = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    cyc();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 2'b01, 1'b1, 1'b0);
      cyc();
      n_checks++;
      if (dn1.valid !== 1'b1 || dn1.data !== 32'(i) || up1.ready !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=1",
                 i, dn1.valid, dn1.data, up1.ready, 32'(i));
      end
    end
    drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    cyc();
    n_checks++;
    if (dn1.valid !== 1'b0) begin n_errors++; $display("FAIL stream_drain: got %b want 0", dn1.valid); end
    cyc();
  endtask

  task automatic test_stall();
    drive(1'b1, 32'hA, 2'b01, 1'b0, 1'b0);
    cyc();
    n_checks++;
    if (dn1.data !== 32'hA || up1.ready !== 1'b1) begin
      n_errors++; $display("FAIL stall_a: got d=%h rdy=%b want d=a rdy=1", dn1.data, up1.ready);
    end
    drive(1'b1, 32'hB, 2'b01, 1'b0, 1'b0);
    cyc();
    n_checks++;
    if (dn1.data !== 32'hA || up1.ready !== 1'b0) begin
      n_errors++; $display("FAIL stall_b: got d=%h rdy=%b want d=a rdy=0", dn1.data, up1.ready);
    end
    drive(1'b1, 32'hC, 2'b01, 1'b0, 1'b0);
    repeat (3) cyc();
    n_checks++;
    if (dn1.valid !== 1'b1 || dn1.data !== 32'hA || up1.ready !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_hold: got v=%b d=%h rdy=%b want v=1 d=a rdy=0",
               dn1.valid, dn1.data, up1.ready);
    end
    n_checks++;
    if (cnt1 !== 16'd4) begin n_errors++; $display("FAIL stall_cnt: got %0d want 4", cnt1); end
    drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    cyc();
    n_checks++;
    if (dn1.valid !== 1'b1 || dn1.data !== 32'hB) begin
      n_errors++; $display("FAIL stall_release: got v=%b d=%h want v=1 d=b", dn1.valid, dn1.data);
    end
    cyc();
    n_checks++;
    if (dn1.valid !== 1'b0 || cnt1 !== 16'd4) begin
      n_errors++; $display("FAIL stall_empty: got v=%b cnt=%0d want v=0 cnt=4", dn1.valid, cnt1);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h10, 2'b10, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h11, 2'b10, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h12, 2'b10, 1'b0, 1'b1);
    cyc();
    n_checks++;
    if (dn1.valid !== 1'b0 || dn1.ctrl !== 2'b00 || up1.ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_full: got v=%b c=%b rdy=%b want v=0 c=00 rdy=1",
               dn1.valid, dn1.ctrl, up1.ready);
    end
    // Accepted upstream in the flush cycle, then dropped.
    drive(1'b1, 32'h13, 2'b10, 1'b0, 1'b1);
    cyc();
    n_checks++;
    if (dn1.valid !== 1'b0) begin n_errors++; $display("FAIL flush_accept: got %b want 0", dn1.valid); end
    drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    repeat (2) cyc();
    n_checks++;
    if (dn1.valid !== 1'b0 || cnt1 !== 16'd6) begin
      n_errors++; $display("FAIL flush_after: got v=%b cnt=%0d want v=0 cnt=6", dn1.valid, cnt1);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 32'h20, 2'b01, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    repeat (20) cyc();
    n_checks++;
    if (cnt4 !== 4'd15) begin n_errors++; $display("FAIL sat_reach: got %0d want 15", cnt4); end
    repeat (3) cyc();
    n_checks++;
    if (cnt4 !== 4'd15) begin n_errors++; $display("FAIL sat_stick: got %0d want 15", cnt4); end
    n_checks++;
    if (cnt1 !== 16'd29) begin n_errors++; $display("FAIL cnt_wide: got %0d want 29", cnt1); end
    drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    cyc();
    n_checks++;
    if (cnt4 !== 4'd15 || cnt1 !== 16'd30 || dn1.valid !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_flush: got c4=%0d c16=%0d v=%b want 15 30 0", cnt4, cnt1, dn1.valid);
    end
    tb_reset = 1'b1;
    drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    cyc();
    n_checks++;
    if (cnt4 !== 4'd0 || cnt1 !== 16'd0) begin
      n_errors++; $display("FAIL sat_reset: got c4=%0d c16=%0d want 0 0", cnt4, cnt1);
    end
    tb_reset = 1'b0;
    cyc();
  endtask

  task automatic test_noskid();
    drive(1'b1, 32'h30, 2'b01, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (up0.ready !== 1'b1) begin n_errors++; $display("FAIL noskid_empty_rdy: got %b want 1", up0.ready); end
    cyc();
    n_checks++;
    if (dn0.valid !== 1'b1 || dn0.data !== 32'h30) begin
      n_errors++; $display("FAIL noskid_load: got v=%b d=%h want v=1 d=30", dn0.valid, dn0.data);
    end
    drive(1'b1, 32'h31, 2'b01, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (up0.ready !== 1'b0) begin n_errors++; $display("FAIL noskid_stall_rdy: got %b want 0", up0.ready); end
    tb_out_ready = 1'b1;
    #1;
    n_checks++;
    if (up0.ready !== 1'b1) begin n_errors++; $display("FAIL noskid_release_rdy: got %b want 1", up0.ready); end
    cyc();
    n_checks++;
    if (dn0.valid !== 1'b1 || dn0.data !== 32'h31) begin
      n_errors++; $display("FAIL noskid_reload: got v=%b d=%h want v=1 d=31", dn0.valid, dn0.data);
    end
    drive(1'b1, 32'h32, 2'b10, 1'b1, 1'b0);
    cyc();
    n_checks++;
    if (dn0.data !== 32'h32 || dn0.ctrl !== 2'b10) begin
      n_errors++; $display("FAIL noskid_b2b: got d=%h c=%b want d=32 c=10", dn0.data, dn0.ctrl);
    end
    drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    cyc();
    n_checks++;
    if (dn0.valid !== 1'b0) begin n_errors++; $display("FAIL noskid_drain: got %b want 0", dn0.valid); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_saturation();
    test_noskid();
    n_checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got %0d/%0d entries want 0/0", q1.size(), q0.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
